ysyx_22041752_icache: RTL and testbench



---
 rtl/ysyx_22041752_icache_pkg.sv | 27 ++
 rtl/ysyx_22041752_icache_array.sv | 70 +++++++
 rtl/ysyx_22041752_icache.sv | 201 ++++++++++++++++++++
 tb/tb_ysyx_22041752_icache.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041752_icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041752_icache_pkg
//  Description : Shared constants for the instruction cache: AXI encodings,
//                default geometry and refill FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041752_icache_pkg;

    // AXI encodings used by the refill master
    localparam logic [1:0] c_BURST_INCR = 2'b01;
    localparam logic [2:0] c_SIZE_4B    = 3'b010;
    localparam logic [1:0] c_RESP_OKAY  = 2'b00;

    // Default cache geometry: 16 lines of 16 bytes
    localparam int c_ICACHE_INDEX_WD  = 4;
    localparam int c_ICACHE_OFFSET_WD = 4;

    // Refill FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MISS_AR = 2'd1,
        S_MISS_R  = 2'd2
    } icache_state_e;

endpackage : ysyx_22041752_icache_pkg
`default_nettype wire

// File: rtl/ysyx_22041752_icache_array.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041752_icache_array
//  Description : Valid/tag/data flop storage for the direct-mapped icache.
//                Asynchronous read port, full-line write port and a global
//                invalidate.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_icache_array #(
    parameter int INST_WD  = 32,
    parameter int TAG_WD   = 24,
    parameter int INDEX_WD = 4,
    parameter int WORD_WD  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    // read port
    input  logic [INDEX_WD-1:0]                       rd_index,
    input  logic [WORD_WD-1:0]                        rd_word,
    input  logic [TAG_WD-1:0]                         rd_tag,
    output logic                                      rd_hit,
    output logic [INST_WD-1:0]                        rd_data,
    // write port
    input  logic                                      wr_en,
    input  logic [INDEX_WD-1:0]                       wr_index,
    input  logic [TAG_WD-1:0]                         wr_tag,
    input  logic                                      wr_valid,
    input  logic [(1<<WORD_WD)-1:0][INST_WD-1:0]      wr_line,
    // clear every valid bit
    input  logic                                      inv_all
);

    localparam int LINES      = 1 << INDEX_WD;
    localparam int LINE_WORDS = 1 << WORD_WD;

    logic [LINES-1:0]                          r_valid;
    logic [TAG_WD-1:0]                         r_tag  [LINES];
    logic [LINE_WORDS-1:0][INST_WD-1:0]        r_data [LINES];

    // Valid bits: reset and invalidate clear them; a line write sets its own
    // bit unless an invalidate lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (inv_all) begin
                r_valid <= '0;
            end
            if (wr_en) begin
                r_valid[wr_index] <= wr_valid & ~inv_all;
            end
        end
    end

    // Tag and data storage are not reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_line;
        end
    end

    // Asynchronous lookup
    always_comb begin
        rd_hit  = r_valid[rd_index] && (r_tag[rd_index] == rd_tag);
        rd_data = r_data[rd_index][rd_word];
    end

endmodule : ysyx_22041752_icache_array
`default_nettype wire

// File: rtl/ysyx_22041752_icache.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041752_icache
//  Description : Direct-mapped blocking instruction cache. One-cycle hits,
//                line refill over an AXI4 read burst on a miss.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_icache
    import ysyx_22041752_icache_pkg::*;
#(
    parameter int ADDR_WD   = 32,
    parameter int INST_WD   = 32,
    parameter int OFFSET_WD = c_ICACHE_OFFSET_WD,
    parameter int INDEX_WD  = c_ICACHE_INDEX_WD
) (
    input  logic               clk,
    input  logic               reset,
    // fetch interface
    input  logic               inst_en,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic [INST_WD-1:0] inst_rdata,
    output logic               cache_miss,
    input  logic               fence_i,
    // AXI read address channel
    output logic               arvalid,
    input  logic               arready,
    output logic [ADDR_WD-1:0] araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    // AXI read data channel
    input  logic               rvalid,
    output logic               rready,
    input  logic [INST_WD-1:0] rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast
);

    localparam int TAG_WD     = ADDR_WD - INDEX_WD - OFFSET_WD;
    localparam int WORD_WD    = OFFSET_WD - 2;
    localparam int LINE_WORDS = 1 << WORD_WD;

    icache_state_e                      r_state, w_state_nxt;
    logic [ADDR_WD-1:0]                 r_miss_addr;
    logic [LINE_WORDS-1:0][INST_WD-1:0] r_line_buf;
    logic [WORD_WD-1:0]                 r_cnt;
    logic                               r_err;
    logic                               r_fence_pend;
    logic                               r_cache_miss;
    logic [INST_WD-1:0]                 r_inst_rdata;

    logic                               w_rd_hit;
    logic [INST_WD-1:0]                 w_rd_data;
    logic                               w_hit_fire;
    logic                               w_miss_start;
    logic                               w_ar_fire;
    logic                               w_beat;
    logic                               w_fill_done;
    logic                               w_err_any;
    logic                               w_inv_all;
    logic [LINE_WORDS-1:0][INST_WD-1:0] w_line;
    logic [WORD_WD-1:0]                 w_req_word;
    logic                               w_unused;

    // Byte-offset bits below the word are never used
    assign w_unused = ^{inst_addr[1:0], r_miss_addr[1:0]};

    ysyx_22041752_icache_array #(
        .INST_WD  (INST_WD),
        .TAG_WD   (TAG_WD),
        .INDEX_WD (INDEX_WD),
        .WORD_WD  (WORD_WD)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (inst_addr[OFFSET_WD+INDEX_WD-1:OFFSET_WD]),
        .rd_word  (inst_addr[OFFSET_WD-1:2]),
        .rd_tag   (inst_addr[ADDR_WD-1:OFFSET_WD+INDEX_WD]),
        .rd_hit   (w_rd_hit),
        .rd_data  (w_rd_data),
        .wr_en    (w_fill_done),
        .wr_index (r_miss_addr[OFFSET_WD+INDEX_WD-1:OFFSET_WD]),
        .wr_tag   (r_miss_addr[ADDR_WD-1:OFFSET_WD+INDEX_WD]),
        .wr_valid (~(w_err_any | r_fence_pend | fence_i)),
        .wr_line  (w_line),
        .inv_all  (w_inv_all)
    );

    // Static AXI burst attributes and registered fetch outputs
    assign araddr     = {r_miss_addr[ADDR_WD-1:OFFSET_WD], {OFFSET_WD{1'b0}}};
    assign arlen      = 8'(LINE_WORDS - 1);
    assign arsize     = c_SIZE_4B;
    assign arburst    = c_BURST_INCR;
    assign inst_rdata = r_inst_rdata;
    assign cache_miss = r_cache_miss;

    // Event decode; a fence on the request cycle forces a miss
    always_comb begin
        w_hit_fire   = (r_state == S_IDLE) && inst_en && w_rd_hit && !fence_i;
        w_miss_start = (r_state == S_IDLE) && inst_en && !(w_rd_hit && !fence_i);
        w_ar_fire    = (r_state == S_MISS_AR) && arready;
        w_beat       = (r_state == S_MISS_R) && rvalid;
        w_fill_done  = w_beat && rlast;
        w_err_any    = r_err || (rresp != c_RESP_OKAY);
        w_inv_all    = ((r_state == S_IDLE) && fence_i)
                     || (w_fill_done && (r_fence_pend || fence_i));
        w_req_word   = r_miss_addr[OFFSET_WD-1:2];
    end

    // Completed line: buffered beats with the final beat merged in directly
    always_comb begin
        w_line        = r_line_buf;
        w_line[r_cnt] = rdata;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and AXI handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_miss_start) begin
                    w_state_nxt = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_nxt = S_MISS_R;
                end
            end
            S_MISS_R: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Miss bookkeeping, beat counter, error/fence tracking and fetch outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_miss_addr  <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_fence_pend <= 1'b0;
            r_cache_miss <= 1'b0;
            r_inst_rdata <= '0;
        end else begin
            if (w_hit_fire) begin
                r_inst_rdata <= w_rd_data;
            end
            if (w_miss_start) begin
                r_miss_addr  <= inst_addr;
                r_cache_miss <= 1'b1;
                r_fence_pend <= 1'b0;
            end
            if ((r_state != S_IDLE) && fence_i) begin
                r_fence_pend <= 1'b1;
            end
            if (w_ar_fire) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (rresp != c_RESP_OKAY) begin
                    r_err <= 1'b1;
                end
            end
            if (w_fill_done) begin
                r_inst_rdata <= w_line[w_req_word];
                r_cache_miss <= 1'b0;
                r_fence_pend <= 1'b0;
            end
        end
    end

    // Refill beat capture
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_line_buf[r_cnt] <= rdata;
        end
    end

endmodule : ysyx_22041752_icache
`default_nettype wire

// File: tb/tb_ysyx_22041752_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22041752_icache
//  Description : Directed self-checking bench for the instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041752_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        cache_miss;
    logic        fence_i;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_22041752_icache dut (
        .clk        (clk),
        .reset      (reset),
        .inst_en    (inst_en),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .cache_miss (cache_miss),
        .fence_i    (fence_i),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast)
    );

    // Backing memory: line 0x80000000 holds 0x11,0x22,0x33,0x44
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {30'd0, a[3:2]} + 32'd1;
        if (a[31:4] == 28'h8000000) return 32'h11 * w;
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic fen);
        inst_en   = 1'b1;
        inst_addr = a;
        fence_i   = fen;
        tick();
        inst_en   = 1'b0;
        fence_i   = 1'b0;
    endtask

    task automatic expect_hit(input logic [31:0] a);
        req(a, 1'b0);
        check("hit_miss_flag", {31'd0, cache_miss}, 32'd0);
        check("hit_rdata", inst_rdata, mem_word(a));
        check("hit_no_ar", {31'd0, arvalid}, 32'd0);
    endtask

    // Full miss: request, AR with optional stall, four beats with optional
    // gaps, an optional error beat and an optional fence during the burst.
    task automatic miss_refill(input logic [31:0] a, input logic fen_req,
                               input int ar_delay, input int r_gap,
                               input int err_beat, input int fence_beat);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        req(a, fen_req);
        check("miss_flag", {31'd0, cache_miss}, 32'd1);
        check("arvalid", {31'd0, arvalid}, 32'd1);
        check("araddr", araddr, base);
        check("arlen", {24'd0, arlen}, 32'd3);
        check("arsize", {29'd0, arsize}, 32'd2);
        check("arburst", {30'd0, arburst}, 32'd1);
        repeat (ar_delay) begin
            tick();
            check("ar_hold_valid", {31'd0, arvalid}, 32'd1);
            check("ar_hold_addr", araddr, base);
            check("ar_hold_miss", {31'd0, cache_miss}, 32'd1);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rready", {31'd0, rready}, 32'd1);
        check("ar_drop", {31'd0, arvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (r_gap) begin
                tick();
                check("gap_miss", {31'd0, cache_miss}, 32'd1);
            end
            rvalid  = 1'b1;
            rdata   = mem_word(base + 32'(4 * i));
            rlast   = (i == 3);
            rresp   = (i == err_beat) ? 2'b10 : 2'b00;
            fence_i = (i == fence_beat);
            tick();
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rresp   = 2'b00;
            fence_i = 1'b0;
        end
        check("fill_miss_clr", {31'd0, cache_miss}, 32'd0);
        check("fill_rdata", inst_rdata, mem_word(a));
        check("fill_rready_drop", {31'd0, rready}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        inst_en   = 1'b0;
        inst_addr = '0;
        fence_i   = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_miss", {31'd0, cache_miss}, 32'd0);
        check("rst_rdata", inst_rdata, 32'd0);
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);

        // Cold miss then hits
        miss_refill(32'h8000_0004, 1'b0, 0, 0, -1, -1);
        expect_hit(32'h8000_000C);
        expect_hit(32'h8000_0000);

        // Conflict on index 0, then the original line misses again with
        // AR backpressure and gapped beats
        miss_refill(32'h8000_0100, 1'b0, 0, 0, -1, -1);
        miss_refill(32'h8000_0000, 1'b0, 5, 2, -1, -1);
        expect_hit(32'h8000_0008);

        // Fence with request in IDLE to a cached line forces a miss
        miss_refill(32'h8000_0004, 1'b1, 0, 0, -1, -1);
        expect_hit(32'h8000_0004);

        // Fence during MISS_R: word delivered, line not kept
        miss_refill(32'h8000_0104, 1'b0, 0, 0, -1, -1);
        miss_refill(32'h8000_0004, 1'b0, 0, 0, -1, 1);
        miss_refill(32'h8000_0004, 1'b0, 0, 0, -1, -1);

        // Reset in the middle of a burst
        req(32'h8000_0040, 1'b0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1;
            rdata  = mem_word(32'h8000_0040 + 32'(4 * i));
            tick();
        end
        rvalid = 1'b0;
        reset  = 1'b1;
        tick();
        check("midrst_arvalid", {31'd0, arvalid}, 32'd0);
        check("midrst_rready", {31'd0, rready}, 32'd0);
        check("midrst_miss", {31'd0, cache_miss}, 32'd0);
        reset = 1'b0;
        tick();
        miss_refill(32'h8000_0000, 1'b0, 0, 0, -1, -1);

        // Error response: word delivered, line not allocated
        miss_refill(32'h8000_0010, 1'b0, 0, 0, 2, -1);
        miss_refill(32'h8000_0010, 1'b0, 0, 0, -1, -1);
        expect_hit(32'h8000_001C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ysyx_22041752_icache
`default_nettype wire
